// File: rtl/mem_arbiter.sv
// Shares one single-port data RAM between instruction fetch (read-only) and the MEM-stage load/store port.
// Optional perf counters (perf_conflict_o, perf_misalign_o) are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter #(
  parameter int RAM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_gnt_o,
  output logic              mem_rvalid_o,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_misalign_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict_o,
  output logic [31:0]       perf_misalign_o
`endif
);

  localparam int SCW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } owner_e;

  owner_e         owner_q, owner_d;
  logic [SCW-1:0] starve_q;
  logic [1:0]     off_q;
  logic [1:0]     size_q;
  logic           uns_q;

  logic           misaligned;
  logic           mem_mis;
  logic           mem_ok;
  logic           if_wins;
  logic           mem_acc;
  logic           if_acc;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [31:0]    load_data;

  // Address bits outside the RAM word index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:RAM_AW+2], if_addr_i[1:0], mem_addr_i[31:RAM_AW+2]};

  always_comb begin
    case (mem_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = mem_addr_i[0];
      2'd2:    misaligned = |mem_addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // A misaligned MEM request is accepted without touching the RAM, leaving it free for IF.
  assign mem_mis  = mem_req_i & misaligned & ~rst;
  assign mem_ok   = mem_req_i & ~misaligned & ~rst;
  assign if_wins  = (starve_q == SCW'(STARVE_MAX));
  assign mem_acc  = mem_ok & ~(if_req_i & if_wins);
  assign if_acc   = if_req_i & ~rst & ~mem_acc;

  assign if_gnt_o       = if_acc;
  assign mem_gnt_o      = mem_mis | mem_acc;
  assign mem_misalign_o = mem_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (mem_mis) begin
      starve_q <= starve_q;
    end else if (!if_req_i || if_acc) begin
      starve_q <= '0;
    end else if (mem_acc && !if_wins) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      if (mem_acc && !mem_we_i) begin
        off_q  <= mem_addr_i[1:0];
        size_q <= mem_size_i;
        uns_q  <= mem_unsigned_i;
      end
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (if_acc) begin
      owner_d = OWN_IF;
    end else if (mem_acc && !mem_we_i) begin
      owner_d = OWN_MEM;
    end
  end

  always_comb begin
    lane_b = ram_rdata_i[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    case (size_q)
      2'd0:    load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'd1:    load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_data = ram_rdata_i;
    endcase
  end

  // Reset masks the return path so a read granted just before reset never surfaces.
  always_comb begin
    if_rvalid_o  = 1'b0;
    if_rdata_o   = '0;
    mem_rvalid_o = 1'b0;
    mem_rdata_o  = '0;
    if (!rst) begin
      case (owner_q)
        OWN_IF: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = ram_rdata_i;
        end
        OWN_MEM: begin
          mem_rvalid_o = 1'b1;
          mem_rdata_o  = load_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_en_o    = if_acc | mem_acc;
    ram_we_o    = 4'b0000;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (if_acc) begin
      ram_addr_o = if_addr_i[RAM_AW+1:2];
    end else if (mem_acc) begin
      ram_addr_o = mem_addr_i[RAM_AW+1:2];
      if (mem_we_i) begin
        case (mem_size_i)
          2'd0: begin
            ram_we_o    = 4'b0001 << mem_addr_i[1:0];
            ram_wdata_o = {4{mem_wdata_i[7:0]}};
          end
          2'd1: begin
            ram_we_o    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            ram_wdata_o = {2{mem_wdata_i[15:0]}};
          end
          default: begin
            ram_we_o    = 4'b1111;
            ram_wdata_o = mem_wdata_i;
          end
        endcase
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_o <= '0;
      perf_misalign_o <= '0;
    end else begin
      if (if_req_i && mem_req_i && !(if_gnt_o && mem_gnt_o)) begin
        perf_conflict_o <= perf_conflict_o + 32'd1;
      end
      if (mem_mis) begin
        perf_misalign_o <= perf_misalign_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural RAM answers the DUT, expected read returns are queued at grant time.
module tb_mem_arbiter;

   localparam int RAM_AW     = 12;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req_i;
   logic [31:0]       if_addr_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [31:0]       if_rdata_o;
   logic              mem_req_i;
   logic              mem_we_i;
   logic [31:0]       mem_addr_i;
   logic [1:0]        mem_size_i;
   logic              mem_unsigned_i;
   logic [31:0]       mem_wdata_i;
   logic              mem_gnt_o;
   logic              mem_rvalid_o;
   logic [31:0]       mem_rdata_o;
   logic              mem_misalign_o;
   logic              ram_en_o;
   logic [3:0]        ram_we_o;
   logic [RAM_AW-1:0] ram_addr_o;
   logic [31:0]       ram_wdata_o;
   logic [31:0]       ram_rdata_i;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t if_q[$];
   exp_t mem_q[$];

   always #5 clk = ~clk;

   mem_arbiter #(.RAM_AW(RAM_AW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .mem_wdata_i(mem_wdata_i),
      .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
      .mem_misalign_o(mem_misalign_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
   );

   // Untouched RAM words read back as a recognisable pattern of their own index.
   function automatic logic [31:0] init_word(input int a);
      return {16'hC0DE, a[15:0]};
   endfunction

   logic [31:0] ram [int];

   // Behavioural single-port RAM: byte-strobed writes, one-cycle read latency.
   always @(posedge clk) begin : ram_model
      logic [31:0] w;
      int a;
      if (ram_en_o) begin
         a = int'(ram_addr_o);
         w = ram.exists(a) ? ram[a] : init_word(a);
         if (ram_we_o == 4'b0000) begin
            ram_rdata_i <= w;
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (ram_we_o[b]) w[8*b +: 8] = ram_wdata_o[8*b +: 8];
            end
            ram[a] = w;
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Scoreboard: every rvalid must match the oldest queued return, in the cycle it was predicted for.
   always @(negedge clk) begin
      exp_t e;
      if (if_rvalid_o) begin
         if (if_q.size() == 0) begin
            checkOutput("if_unexpected_rvalid", 32'(if_rvalid_o), 32'd0);
         end else begin
            e = if_q.pop_front();
            checkOutput("if_rdata", if_rdata_o, e.data);
            checkOutput("if_rvalid_cycle", cyc, e.cyc);
         end
      end else if (if_q.size() != 0 && if_q[0].cyc <= cyc) begin
         e = if_q.pop_front();
         checkOutput("if_rvalid_missing", 32'(if_rvalid_o), 32'd1);
      end
      if (mem_rvalid_o) begin
         if (mem_q.size() == 0) begin
            checkOutput("mem_unexpected_rvalid", 32'(mem_rvalid_o), 32'd0);
         end else begin
            e = mem_q.pop_front();
            checkOutput("mem_rdata", mem_rdata_o, e.data);
            checkOutput("mem_rvalid_cycle", cyc, e.cyc);
         end
      end else if (mem_q.size() != 0 && mem_q[0].cyc <= cyc) begin
         e = mem_q.pop_front();
         checkOutput("mem_rvalid_missing", 32'(mem_rvalid_o), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one MEM request, waits (bounded) for its grant and checks the RAM-side effect.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata, input logic exp_mis,
                                input logic [31:0] exp_rdata, input logic [3:0] exp_we,
                                input logic [31:0] exp_wdata);
      int n = 0;
      mem_req_i      = 1'b1;
      mem_we_i       = we;
      mem_addr_i     = addr;
      mem_size_i     = size;
      mem_unsigned_i = uns;
      mem_wdata_i    = wdata;
      @(negedge clk);
      while (!mem_gnt_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("mem_gnt", 32'(mem_gnt_o), 32'd1);
      checkOutput("mem_misalign", 32'(mem_misalign_o), 32'(exp_mis));
      if (exp_mis) begin
         checkOutput("misaligned_ram_en", 32'(ram_en_o), 32'd0);
      end else if (we) begin
         checkOutput("store_we", 32'(ram_we_o), 32'(exp_we));
         checkOutput("store_wdata", ram_wdata_o, exp_wdata);
         checkOutput("store_addr", 32'(ram_addr_o), 32'(addr[13:2]));
      end else begin
         checkOutput("load_we", 32'(ram_we_o), 32'd0);
         mem_q.push_back('{data: exp_rdata, cyc: cyc + 1});
      end
      tick();
      mem_req_i = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      if_req_i       = 1'b1;
      if_addr_i      = 32'h0;
      mem_req_i      = 1'b1;
      mem_we_i       = 1'b1;
      mem_addr_i     = 32'h10;
      mem_size_i     = 2'd2;
      mem_unsigned_i = 1'b0;
      mem_wdata_i    = 32'h0;

      // Requests held during reset must not be granted.
      @(negedge clk);
      checkOutput("rst_if_gnt", 32'(if_gnt_o), 32'd0);
      checkOutput("rst_mem_gnt", 32'(mem_gnt_o), 32'd0);
      checkOutput("rst_ram_en", 32'(ram_en_o), 32'd0);
      checkOutput("rst_ram_we", 32'(ram_we_o), 32'd0);
      checkOutput("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
      checkOutput("rst_mem_rdata", mem_rdata_o, 32'd0);
      tick();
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // Word store then load.
      applyStimulus(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 4'b1111, 32'hDEADBEEF);
      applyStimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 4'b0, 32'h0);

      // Byte and half lanes, signed and unsigned.
      applyStimulus(1'b1, 32'h13, 2'd0, 1'b0, 32'h12345680, 1'b0, 32'h0, 4'b1000, 32'h80808080);
      applyStimulus(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFF80, 4'b0, 32'h0);
      applyStimulus(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 1'b0, 32'h00000080, 4'b0, 32'h0);
      applyStimulus(1'b1, 32'h12, 2'd1, 1'b0, 32'hABCD8001, 1'b0, 32'h0, 4'b1100, 32'h80018001);
      applyStimulus(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFF8001, 4'b0, 32'h0);
      applyStimulus(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 1'b0, 32'h00008001, 4'b0, 32'h0);
      applyStimulus(1'b0, 32'h10, 2'd0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFEF, 4'b0, 32'h0);
      applyStimulus(1'b0, 32'h11, 2'd0, 1'b1, 32'h0, 1'b0, 32'h000000BE, 4'b0, 32'h0);
      applyStimulus(1'b0, 32'h10, 2'd1, 1'b0, 32'h0, 1'b0, 32'hFFFFBEEF, 4'b0, 32'h0);
      applyStimulus(1'b1, 32'h20, 2'd1, 1'b0, 32'h55551234, 1'b0, 32'h0, 4'b0011, 32'h12341234);
      applyStimulus(1'b1, 32'h21, 2'd0, 1'b0, 32'hAAAAAA77, 1'b0, 32'h0, 4'b0010, 32'h77777777);
      applyStimulus(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0, 32'hC0DE7734, 4'b0, 32'h0);
      applyStimulus(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'h8001BEEF, 4'b0, 32'h0);

      // Misaligned LW with an IF fetch pending: both granted, only IF uses the RAM.
      if_req_i       = 1'b1;
      if_addr_i      = 32'h10;
      mem_req_i      = 1'b1;
      mem_we_i       = 1'b0;
      mem_addr_i     = 32'h6;
      mem_size_i     = 2'd2;
      @(negedge clk);
      checkOutput("mis_mem_gnt", 32'(mem_gnt_o), 32'd1);
      checkOutput("mis_flag", 32'(mem_misalign_o), 32'd1);
      checkOutput("mis_if_gnt", 32'(if_gnt_o), 32'd1);
      checkOutput("mis_ram_addr", 32'(ram_addr_o), 32'd4);
      if_q.push_back('{data: 32'h8001BEEF, cyc: cyc + 1});
      tick();
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;
      applyStimulus(1'b0, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
      applyStimulus(1'b1, 32'h1, 2'd1, 1'b0, 32'hFFFF, 1'b1, 32'h0, 4'b0, 32'h0);
      applyStimulus(1'b0, 32'h2, 2'd1, 1'b1, 32'h0, 1'b0, 32'h0000C0DE, 4'b0, 32'h0);

      // Starvation: MEM wins STARVE_MAX times, then IF is forced through.
      if_req_i   = 1'b1;
      if_addr_i  = 32'h0;
      mem_req_i  = 1'b1;
      mem_we_i   = 1'b0;
      mem_addr_i = 32'h10;
      mem_size_i = 2'd2;
      for (int i = 0; i < 10; i++) begin
         logic exp_if;
         exp_if = (i % (STARVE_MAX + 1)) == STARVE_MAX;
         @(negedge clk);
         checkOutput($sformatf("starve_if_gnt_%0d", i), 32'(if_gnt_o), 32'(exp_if));
         checkOutput($sformatf("starve_mem_gnt_%0d", i), 32'(mem_gnt_o), 32'(!exp_if));
         if (exp_if) if_q.push_back('{data: init_word(0), cyc: cyc + 1});
         else        mem_q.push_back('{data: 32'h8001BEEF, cyc: cyc + 1});
         tick();
      end
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;
      tick();

      // Back-to-back fetches.
      if_req_i  = 1'b1;
      if_addr_i = 32'h0;
      @(negedge clk);
      checkOutput("b2b_gnt0", 32'(if_gnt_o), 32'd1);
      if_q.push_back('{data: init_word(0), cyc: cyc + 1});
      tick();
      if_addr_i = 32'h4;
      @(negedge clk);
      checkOutput("b2b_gnt1", 32'(if_gnt_o), 32'd1);
      if_q.push_back('{data: init_word(1), cyc: cyc + 1});
      tick();
      if_req_i = 1'b0;
      tick();

      // Reset right after an IF grant: the pending return is dropped.
      if_req_i  = 1'b1;
      if_addr_i = 32'h8;
      @(negedge clk);
      checkOutput("rstrd_if_gnt", 32'(if_gnt_o), 32'd1);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("rstrd_if_rvalid", 32'(if_rvalid_o), 32'd0);
         checkOutput("rstrd_if_rdata", if_rdata_o, 32'd0);
         checkOutput("rstrd_if_gnt_forced", 32'(if_gnt_o), 32'd0);
         checkOutput("rstrd_ram_en", 32'(ram_en_o), 32'd0);
         tick();
      end
      rst      = 1'b0;
      if_req_i = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
      tick();

      // Build the starve count to its limit, reset, and confirm MEM wins again afterwards.
      if_req_i   = 1'b1;
      if_addr_i  = 32'h0;
      mem_req_i  = 1'b1;
      mem_we_i   = 1'b0;
      mem_addr_i = 32'h10;
      mem_size_i = 2'd2;
      for (int i = 0; i < STARVE_MAX; i++) begin
         @(negedge clk);
         checkOutput($sformatf("pre_rst_mem_gnt_%0d", i), 32'(mem_gnt_o), 32'd1);
         if (i < STARVE_MAX - 1) mem_q.push_back('{data: 32'h8001BEEF, cyc: cyc + 1});
         tick();
      end
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst2_mem_gnt", 32'(mem_gnt_o), 32'd0);
      checkOutput("rst2_mem_rvalid", 32'(mem_rvalid_o), 32'd0);
      checkOutput("rst2_mem_rdata", mem_rdata_o, 32'd0);
      checkOutput("rst2_misalign", 32'(mem_misalign_o), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_mem_gnt", 32'(mem_gnt_o), 32'd1);
      checkOutput("post_rst_if_gnt", 32'(if_gnt_o), 32'd0);
      mem_q.push_back('{data: 32'h8001BEEF, cyc: cyc + 1});
      tick();
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;

      // Idle RAM interface is fully zeroed even with stale MEM inputs.
      mem_we_i    = 1'b1;
      mem_addr_i  = 32'hFFC;
      mem_wdata_i = 32'hFFFFFFFF;
      tick();
      @(negedge clk);
      checkOutput("idle_ram_en", 32'(ram_en_o), 32'd0);
      checkOutput("idle_ram_we", 32'(ram_we_o), 32'd0);
      checkOutput("idle_ram_addr", 32'(ram_addr_o), 32'd0);
      checkOutput("idle_ram_wdata", ram_wdata_o, 32'd0);
      tick();
      tick();
      checkOutput("if_queue_drained", if_q.size(), 32'd0);
      checkOutput("mem_queue_drained", mem_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
